// File: rtl/wb_pkg.sv
// Shared writeback definitions: RV32I opcodes, load funct3 codes,
// load-queue entry layout and the load byte-lane extraction helper.
package wb_pkg;

  localparam int LQ_RA_W = 5;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [LQ_RA_W-1:0] rd;
    logic [2:0]         funct3;
    logic [1:0]         addr_lo;
  } lq_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } ld_res_t;

  function automatic ld_res_t load_extract(input logic [2:0]  funct3,
                                           input logic [1:0]  addr_lo,
                                           input logic [31:0] word);
    ld_res_t     res;
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {addr_lo, 3'b000};
    b       = shifted[7:0];
    h       = addr_lo[1] ? word[31:16] : word[15:0];
    res     = '0;
    case (funct3)
      F3_LB:  res = '{valid: 1'b1, data: {{24{b[7]}}, b}};
      F3_LBU: res = '{valid: 1'b1, data: {24'h0, b}};
      F3_LH:  res = '{valid: 1'b1, data: {{16{h[15]}}, h}};
      F3_LHU: res = '{valid: 1'b1, data: {16'h0, h}};
      F3_LW:  res = '{valid: 1'b1, data: word};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_load_queue.sv
// Outstanding-load FIFO; exposes every slot plus a per-slot valid bit so the
// parent can build the pending-register mask. Push and pop never coincide.
module wb_load_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  lq_entry_t             push_dat_i,
  input  logic                  pop_i,
  output lq_entry_t             head_o,
  output logic [CW-1:0]         count_o,
  output lq_entry_t [DEPTH-1:0] ent_o,
  output logic [DEPTH-1:0]      ent_vld_o
);

  localparam int PW = $clog2(DEPTH);

  lq_entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]      vld_q;
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_dat_i;
        vld_q[wr_q] <= 1'b1;
        wr_q        <= PW'(wr_q + 1'b1);
      end
      if (pop_i) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= PW'(rd_q + 1'b1);
      end
      if (push_i && !pop_i)
        cnt_q <= CW'(cnt_q + 1'b1);
      else if (pop_i && !push_i)
        cnt_q <= CW'(cnt_q - 1'b1);
    end
  end

  assign head_o    = mem_q[rd_q];
  assign count_o   = cnt_q;
  assign ent_o     = mem_q;
  assign ent_vld_o = vld_q;

endmodule

// File: rtl/wb_unit_lq.sv
// Registered single-port writeback with an in-order load queue; writes land
// one cycle after accept/response. in_ready drops during a response or when full.
module wb_unit_lq
  import wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = LQ_RA_W,
  parameter int LQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 instr,
  input  logic [XLEN-1:0]             alu_result,
  input  logic [1:0]                  addr_lo,
  input  logic                        mem_rsp_valid,
  input  logic [XLEN-1:0]             mem_rsp_data,
  output logic [RA_W-1:0]             reg_write_addr,
  output logic [XLEN-1:0]             reg_write_data,
  output logic                        reg_write_enable,
  output logic [(1<<RA_W)-1:0]        pending_mask,
  output logic [$clog2(LQ_DEPTH):0]   lq_count,
  output logic                        err_sticky
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic [6:0]      opc;
  logic [RA_W-1:0] rd;
  logic [2:0]      funct3;
  logic            is_direct, is_load, accept, push, pop, stray;
  logic            unused_instr;

  lq_entry_t                head;
  lq_entry_t [LQ_DEPTH-1:0] ent;
  logic [LQ_DEPTH-1:0]      ent_vld;
  logic [CW-1:0]            cnt;
  ld_res_t                  ext;

  logic            we_d, we_q, err_d, err_q;
  logic [RA_W-1:0] waddr_d, waddr_q;
  logic [XLEN-1:0] wdata_d, wdata_q;

  assign opc          = instr[6:0];
  assign rd           = instr[11:7];
  assign funct3       = instr[14:12];
  assign unused_instr = ^instr[31:15];

  assign is_direct = (opc == OPC_OP) || (opc == OPC_OPIMM) || (opc == OPC_LUI) ||
                     (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR);
  assign is_load   = (opc == OPC_LOAD);

  // Forcing in_ready low during a response keeps the write port single-sourced.
  assign in_ready = !mem_rsp_valid && (cnt != CW'(LQ_DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && is_load;
  assign pop      = mem_rsp_valid && (cnt != '0);
  assign stray    = mem_rsp_valid && (cnt == '0);

  wb_load_queue #(.DEPTH(LQ_DEPTH), .CW(CW)) u_lq (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i ('{rd: rd, funct3: funct3, addr_lo: addr_lo}),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (cnt),
    .ent_o      (ent),
    .ent_vld_o  (ent_vld)
  );

  assign ext = load_extract(head.funct3, head.addr_lo, mem_rsp_data);

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q | stray;
    if (accept && is_direct && (rd != '0)) begin
      we_d    = 1'b1;
      waddr_d = rd;
      wdata_d = alu_result;
    end else if (pop && (head.rd != '0) && ext.valid) begin
      we_d    = 1'b1;
      waddr_d = head.rd;
      wdata_d = ext.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++)
      if (ent_vld[i]) pending_mask[ent[i].rd] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  assign reg_write_enable = we_q;
  assign reg_write_addr   = waddr_q;
  assign reg_write_data   = wdata_q;
  assign lq_count         = cnt;
  assign err_sticky       = err_q;

endmodule

// File: tb/tb_wb_unit_lq.sv
// Directed bench for wb_unit_lq: direct writes, load alignment, queue ordering,
// full-queue back-pressure, no-write pops, stray responses and mid-run reset.
module tb_wb_unit_lq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] alu_result;
  logic [1:0]  addr_lo;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic        reg_write_enable;
  logic [31:0] pending_mask;
  logic [2:0]  lq_count;
  logic        err_sticky;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_unit_lq #(.XLEN(32), .RA_W(5), .LQ_DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .instr            (instr),
    .alu_result       (alu_result),
    .addr_lo          (addr_lo),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .reg_write_addr   (reg_write_addr),
    .reg_write_data   (reg_write_data),
    .reg_write_enable (reg_write_enable),
    .pending_mask     (pending_mask),
    .lq_count         (lq_count),
    .err_sticky       (err_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ins(input logic [6:0] opc, input logic [4:0] rd,
                                      input logic [2:0] f3);
    return {17'b0, f3, rd, opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] i, input logic [1:0] a);
    in_valid = 1'b1;
    instr    = i;
    addr_lo  = a;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; alu_result = '0; addr_lo = '0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #12;
    chk("rst_we",    32'(reg_write_enable), 32'd0);
    chk("rst_addr",  32'(reg_write_addr),   32'd0);
    chk("rst_data",  reg_write_data,        32'd0);
    chk("rst_cnt",   32'(lq_count),         32'd0);
    chk("rst_mask",  pending_mask,          32'd0);
    chk("rst_err",   32'(err_sticky),       32'd0);
    rst = 1'b0;
    tick();
    chk("rst_rdy",   32'(in_ready),         32'd1);

    // 1: addi x5
    alu_result = 32'h0000_1234;
    issue(ins(7'b0010011, 5'd5, 3'b000), 2'd0);
    chk("t1_we",   32'(reg_write_enable), 32'd1);
    chk("t1_addr", 32'(reg_write_addr),   32'd5);
    chk("t1_data", reg_write_data,        32'h0000_1234);
    tick();
    chk("t1_we_off", 32'(reg_write_enable), 32'd0);
    chk("t1_hold",   reg_write_data,        32'h0000_1234);

    // 2: lb x7, lane 2, response three cycles after issue
    issue(ins(7'b0000011, 5'd7, 3'b000), 2'd2);
    chk("t2_cnt",  32'(lq_count), 32'd1);
    chk("t2_mask", pending_mask,  32'h0000_0080);
    tick(); tick();
    chk("t2_we_wait", 32'(reg_write_enable), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1280_3456;
    #1;
    chk("t2_rdy_rsp",  32'(in_ready),  32'd0);
    chk("t2_mask_rsp", pending_mask,   32'h0000_0080);
    tick();
    mem_rsp_valid = 1'b0;
    chk("t2_we",   32'(reg_write_enable), 32'd1);
    chk("t2_addr", 32'(reg_write_addr),   32'd7);
    chk("t2_data", reg_write_data,        32'hFFFF_FF80);
    chk("t2_mask_clr", pending_mask,      32'd0);

    // 3: lhu x3 lane 3, lbu x4 lane 0, back-to-back responses
    issue(ins(7'b0000011, 5'd3, 3'b101), 2'd3);
    issue(ins(7'b0000011, 5'd4, 3'b100), 2'd0);
    chk("t3_cnt",  32'(lq_count), 32'd2);
    chk("t3_mask", pending_mask,  32'h0000_0018);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBEEF_0011;
    tick();
    mem_rsp_data = 32'h0000_00AB;
    chk("t3_addr_a", 32'(reg_write_addr), 32'd3);
    chk("t3_data_a", reg_write_data,      32'h0000_BEEF);
    chk("t3_mask_a", pending_mask,        32'h0000_0010);
    tick();
    mem_rsp_valid = 1'b0;
    chk("t3_we_b",   32'(reg_write_enable), 32'd1);
    chk("t3_addr_b", 32'(reg_write_addr),   32'd4);
    chk("t3_data_b", reg_write_data,        32'h0000_00AB);

    // 4: fill queue with lw x8..x11
    for (int r = 8; r < 12; r++) issue(ins(7'b0000011, 5'(r), 3'b010), 2'd1);
    chk("t4_cnt",  32'(lq_count), 32'd4);
    chk("t4_mask", pending_mask,  32'h0000_0F00);
    in_valid = 1'b1; instr = ins(7'b0110011, 5'd12, 3'b000); alu_result = 32'h0000_00A5;
    #1;
    chk("t4_rdy_full", 32'(in_ready), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_1111;
    #1;
    chk("t4_rdy_rsp", 32'(in_ready), 32'd0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("t4_rdy_after", 32'(in_ready),      32'd1);
    chk("t4_wr8_addr",  32'(reg_write_addr), 32'd8);
    chk("t4_wr8_data",  reg_write_data,      32'h1111_1111);
    tick();
    in_valid = 1'b0;
    chk("t4_add_addr", 32'(reg_write_addr), 32'd12);
    chk("t4_add_data", reg_write_data,      32'h0000_00A5);
    respond(32'h2222_2222);
    respond(32'h3333_3333);
    respond(32'h4444_4444);
    chk("t4_last_addr", 32'(reg_write_addr), 32'd11);
    chk("t4_last_data", reg_write_data,      32'h4444_4444);
    chk("t4_cnt_end",   32'(lq_count),       32'd0);

    // 5: rd=0 load and reserved funct3 load pop without writing
    issue(ins(7'b0000011, 5'd0, 3'b010), 2'd0);
    issue(ins(7'b0000011, 5'd9, 3'b011), 2'd0);
    chk("t5_cnt",  32'(lq_count), 32'd2);
    chk("t5_mask", pending_mask,  32'h0000_0200);
    respond(32'hDEAD_BEEF);
    chk("t5_we_a",  32'(reg_write_enable), 32'd0);
    chk("t5_cnt_a", 32'(lq_count),         32'd1);
    respond(32'hCAFE_F00D);
    chk("t5_we_b",  32'(reg_write_enable), 32'd0);
    chk("t5_cnt_b", 32'(lq_count),         32'd0);
    chk("t5_hold",  32'(reg_write_addr),   32'd11);

    // 6: stray response, then reset with loads queued
    respond(32'h5555_5555);
    chk("t6_we",  32'(reg_write_enable), 32'd0);
    chk("t6_err", 32'(err_sticky),       32'd1);
    issue(ins(7'b0000011, 5'd5, 3'b010), 2'd0);
    issue(ins(7'b0000011, 5'd6, 3'b010), 2'd0);
    chk("t6_cnt", 32'(lq_count), 32'd2);
    rst = 1'b1;
    #1;
    chk("t6_rst_cnt",  32'(lq_count),   32'd0);
    chk("t6_rst_mask", pending_mask,    32'd0);
    chk("t6_rst_err",  32'(err_sticky), 32'd0);
    rst = 1'b0;
    tick();
    respond(32'h6666_6666);
    chk("t6_stray_err", 32'(err_sticky),       32'd1);
    chk("t6_stray_we",  32'(reg_write_enable), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_unit_lq.md
Name: wb_unit_lq

Overview:
Second-generation writeback stage. It replaces the purely combinational writeback with a registered, single-write-port unit. The unit tracks outstanding loads in a load queue, so variable-latency memory responses are accepted. It performs byte-lane alignment and sign extension of load data, and retires ALU-class results. It sits between the MEM stage and the register file, and exports a pending-load mask to the hazard unit.

Parameters:
XLEN, 32, datapath width (32 only; alignment logic is fixed at 4 byte lanes)
RA_W, 5, register address width
LQ_DEPTH, 4, outstanding-load queue depth (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  unit accepts the instruction this cycle
instr  in  32  instruction word (RV32I encoding)
alu_result  in  XLEN  result for OP/OP-IMM/LUI/AUIPC/JAL/JALR
addr_lo  in  2  load effective address bits [1:0]
mem_rsp_valid  in  1  memory returns load data (no back-pressure)
mem_rsp_data  in  XLEN  raw aligned word from memory
reg_write_addr  out  RA_W  registered rd
reg_write_data  out  XLEN  registered write data
reg_write_enable  out  1  registered one-cycle write strobe
pending_mask  out  2**RA_W  bit r set while any queued load targets xr
lq_count  out  clog2(LQ_DEPTH)+1  queue occupancy
err_sticky  out  1  response received with empty queue; cleared only by rst

Behaviour:
- Reset (async, active-high): all outputs 0, queue empty, err_sticky 0. Reset mid-operation discards all queued loads; later stray responses then set err_sticky.
- Accept: accept = in_valid && in_ready, where in_ready = !mem_rsp_valid && (lq_count != LQ_DEPTH). The combinational path from mem_rsp_valid to in_ready is intentional.
- Classification is by opcode:
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: "direct".
  - LOAD: "load".
  - Anything else (store, branch, fence, system, illegal): consumed, no effect.
- Direct, accepted: next cycle reg_write_enable=1 iff rd!=0, with reg_write_addr=rd and reg_write_data=alu_result. Latency is 1.
- Load, accepted: push {rd, funct3, addr_lo} into the queue. Entries with rd=0 and unknown funct3 are pushed too, so every response is matched.
- Response: when mem_rsp_valid and the queue is non-empty, pop the head. Next cycle write the extracted value if rd!=0 and funct3 is valid; otherwise the pop produces no write. Extraction rules:
  - lb/lbu: byte at lane addr_lo, sign- or zero-extended.
  - lh/lhu: halfword at lane addr_lo[1], sign- or zero-extended; addr_lo[0] is ignored.
  - lw: full word; addr_lo is ignored.
  - funct3 011, 110, 111: no write.
- Response with empty queue: dropped, err_sticky <= 1, no write.
- Single write port: a response and an accept never coincide because in_ready is forced low, so at most one write source per cycle.
- Ordering: responses return in load-issue order (FIFO). Direct writes may overtake older pending loads. The hazard unit uses pending_mask to stall dependent issue.
- reg_write_enable is a single-cycle pulse. When it is 0, reg_write_addr and reg_write_data hold their last values.
- Full queue: in_ready=0 even for direct instructions (simple, decided).
- Simultaneous push and pop are impossible by construction. Pointers wrap modulo LQ_DEPTH.
- pending_mask is combinational from valid queue entries. Bit 0 is always 0.

Decomposition:
- Package wb_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR);
  - funct3 load codes;
  - the lq_entry_t typedef {rd, funct3, addr_lo};
  - function load_extract(funct3, addr_lo, word) returning {valid, data}.
- One sub-module, wb_load_queue: parametrised FIFO with push/pop/count/entries-valid outputs for mask generation.

Test Plan:
1. After reset, issue addi with rd=5 and alu_result=0x0000_1234 -> next cycle enable=1, addr=5, data=0x1234; enable=0 the cycle after.
2. Issue lb with rd=7 and addr_lo=2, respond 3 cycles later with 0x12_80_34_56 -> pending_mask[7]=1 until the response; write data=0xFFFF_FF80 one cycle after the response.
3. Issue lhu with rd=3 and addr_lo=3, then lbu with rd=4 and addr_lo=0, then responses 0xBEEF_0011 and 0x0000_00AB in order -> x3=0x0000_BEEF, then x4=0x0000_00AB; writes occur in issue order.
4. Issue 4 loads with no response -> lq_count=4, in_ready=0 even for an add; one response -> in_ready=0 that cycle, 1 the next.
5. Load with rd=0 and one with funct3=011, each responded -> queue pops, no write strobe, lq_count returns to 0.
6. mem_rsp_valid with empty queue -> no write, err_sticky=1; assert rst mid-stream with 2 loads queued -> lq_count=0, pending_mask=0, err_sticky=0.
